// File: rtl/main_mem_arbiter_if.sv
// Main-memory port bundle: one transaction at a time,
// held stable by the master until the slave returns mem_ready.
interface main_mem_arbiter_if #(
  parameter int LINE_W = 512
) ();
  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic [LINE_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/main_mem_arbiter.sv
// Main-memory arbiter: write-back drain, data and program refill.
// Define MAIN_ARB_RR_EN for round-robin between DATA and PROG.
module main_mem_arbiter #(
  parameter int WB_BURST = 4,
  parameter int LINE_W   = 512
) (
  input  logic              main_clk,
  input  logic              rst_n,
  input  logic              is_req_f_prog,
  input  logic [17:0]       req_addr_f_prog,
  input  logic              is_req_f_data,
  input  logic [17:0]       req_addr_f_data,
  input  logic              fifo_empty,
  input  logic [31:0]       write_back_addr,
  input  logic [31:0]       write_back_data,
  output logic              wb_pop,
  main_mem_arbiter_if.master mem,
  output logic [LINE_W-1:0] line_data,
  output logic              prog_line_we,
  output logic              data_line_we,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    G_NONE,
    G_WB,
    G_DATA,
    G_PROG
  } grant_t;

  localparam logic [3:0] BURST = 4'(WB_BURST);

  state_t     state;
  grant_t     grant;
  grant_t     pick;
  logic [2:0] wb_cnt;
  logic       wb_ok;
  logic       data_ok;
  logic       prog_ok;

`ifdef MAIN_ARB_RR_EN
  logic last_prog;
`endif

  // data refill waits for the write-back FIFO to drain
  assign wb_ok   = !fifo_empty &&
                   (({1'b0, wb_cnt} < BURST) || !is_req_f_prog);
  assign data_ok = is_req_f_data && fifo_empty;
  assign prog_ok = is_req_f_prog;

  always_comb begin
    pick = G_NONE;
`ifdef MAIN_ARB_RR_EN
    if (wb_ok)
      pick = G_WB;
    else if (data_ok && prog_ok)
      pick = last_prog ? G_DATA : G_PROG;
    else if (data_ok)
      pick = G_DATA;
    else if (prog_ok)
      pick = G_PROG;
`else
    if (wb_ok)
      pick = G_WB;
    else if (data_ok)
      pick = G_DATA;
    else if (prog_ok)
      pick = G_PROG;
`endif
  end

  always_ff @(posedge main_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      grant         <= G_NONE;
      wb_cnt        <= '0;
      busy          <= 1'b0;
      wb_pop        <= 1'b0;
      prog_line_we  <= 1'b0;
      data_line_we  <= 1'b0;
      line_data     <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
`ifdef MAIN_ARB_RR_EN
      last_prog     <= 1'b1;
`endif
    end else begin
      wb_pop       <= 1'b0;
      prog_line_we <= 1'b0;
      data_line_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fifo_empty)
            wb_cnt <= '0;
          if (pick != G_NONE) begin
            grant       <= pick;
            state       <= REQ;
            busy        <= 1'b1;
            mem.mem_req <= 1'b1;
            unique case (pick)
              G_WB: begin
                mem.mem_we    <= 1'b1;
                mem.mem_addr  <= write_back_addr;
                mem.mem_wdata <= write_back_data;
                if (wb_cnt != 3'd7)
                  wb_cnt <= wb_cnt + 3'd1;
              end
              G_DATA: begin
                mem.mem_we    <= 1'b0;
                mem.mem_addr  <= {8'b0, req_addr_f_data, 6'b0};
                mem.mem_wdata <= '0;
`ifdef MAIN_ARB_RR_EN
                last_prog     <= 1'b0;
`endif
              end
              G_PROG: begin
                mem.mem_we    <= 1'b0;
                mem.mem_addr  <= {8'b0, req_addr_f_prog, 6'b0};
                mem.mem_wdata <= '0;
                wb_cnt        <= '0;
`ifdef MAIN_ARB_RR_EN
                last_prog     <= 1'b1;
`endif
              end
              default: ;
            endcase
          end
        end
        REQ: begin
          if (mem.mem_ready) begin
            mem.mem_req <= 1'b0;
            state       <= DONE;
            if (!mem.mem_we)
              line_data <= mem.mem_rdata;
            unique case (1'b1)
              (grant == G_WB):   wb_pop       <= 1'b1;
              (grant == G_DATA): data_line_we <= 1'b1;
              (grant == G_PROG): prog_line_we <= 1'b1;
              default: ;
            endcase
          end
        end
        DONE: begin
          state <= IDLE;
          grant <= G_NONE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
